// File: rtl/fft_mag_streamer.sv
// fft_mag_streamer: captures one FFT result frame on fft_finish and streams
// one magnitude estimate per bin over a valid/ready interface.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   fft_data     N*MSB flat result bus, bin i at [MSB*i +: MSB]
//   fft_finish   one-cycle pulse, fft_data valid this cycle
//   out_data     unsigned magnitude estimate (MSB/2+1 bits)
//   out_index    natural-order bin number of out_data
//   out_valid    beat valid
//   out_ready    consumer accepts the current beat
//   out_last     beat carries bin N-1
//   busy         frame captured and not yet fully transferred
//   overrun      one-cycle pulse, a frame was dropped
module fft_mag_streamer #(
  parameter int unsigned N      = 16,
  parameter int unsigned MSB    = 16,
  parameter int unsigned BITREV = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MSB*N-1:0]       fft_data,
  input  logic                   fft_finish,
  output logic [MSB/2:0]         out_data,
  output logic [$clog2(N)-1:0]   out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned H = MSB / 2;
  localparam int unsigned W = H + 1;
  localparam int unsigned A = $clog2(N);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             state_q, state_d;
  logic [N*MSB-1:0]   frame_q;
  logic [A-1:0]       cnt_d;
  logic [W-1:0]       data_d;
  logic               valid_d, last_d, busy_d, overrun_d;
  logic               xfer, final_beat, start;
  logic [A-1:0]       cnt_nxt;
  logic [MSB-1:0]     nxt_word;

  // Buffer slot holding natural-order bin k.
  function automatic logic [A-1:0] slot_of(input logic [A-1:0] k);
    logic [A-1:0] r;
    for (int i = 0; i < int'(A); i++) r[i] = k[int'(A) - 1 - i];
    return (BITREV != 0) ? r : k;
  endfunction

  // max(|re|,|im|) + min(|re|,|im|)/2; absolute values fit in H unsigned bits.
  function automatic logic [W-1:0] mag(input logic [MSB-1:0] w);
    logic [H-1:0] re, im, ar, ai, mx, mn;
    re = w[MSB-1:H];
    im = w[H-1:0];
    ar = re[H-1] ? (~re + H'(1)) : re;
    ai = im[H-1] ? (~im + H'(1)) : im;
    if (ar >= ai) begin
      mx = ar;
      mn = ai;
    end else begin
      mx = ai;
      mn = ar;
    end
    return W'(mx) + W'(mn >> 1);
  endfunction

  assign xfer       = out_valid && out_ready;
  assign final_beat = xfer && (out_index == A'(N - 1));
  // A new frame is accepted when idle or on the edge that retires the last beat.
  assign start      = fft_finish && ((state_q == S_IDLE) || final_beat);
  assign cnt_nxt    = out_index + A'(1);
  assign nxt_word   = frame_q[MSB*int'(slot_of(cnt_nxt)) +: MSB];

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = out_index;
    data_d    = out_data;
    valid_d   = out_valid;
    last_d    = out_last;
    busy_d    = busy;
    overrun_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          cnt_d   = '0;
          data_d  = mag(fft_data[MSB*int'(slot_of('0)) +: MSB]);
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_STREAM: begin
        if (start) begin
          cnt_d   = '0;
          data_d  = mag(fft_data[MSB*int'(slot_of('0)) +: MSB]);
          last_d  = 1'b0;
        end else if (final_beat) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          if (xfer) begin
            cnt_d  = cnt_nxt;
            data_d = mag(nxt_word);
            last_d = (cnt_nxt == A'(N - 1));
          end
          overrun_d = fft_finish;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_index <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_index <= cnt_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
      overrun   <= overrun_d;
    end
  end

  // Frame buffer; contents are irrelevant until the first capture.
  always_ff @(posedge clk) begin
    if (start) frame_q <= fft_data;
  end

endmodule

// File: tb/tb_fft_mag_streamer.sv
module tb_fft_mag_streamer;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [16*N-1:0] fft_data;
  logic           fft_finish;
  logic           out_ready;

  logic [8:0] d0, d1;
  logic [3:0] i0, i1;
  logic       v0, v1, l0, l1, b0, b1, o0, o1;

  int errors = 0;
  int checks = 0;

  typedef struct { int idx; int m0; int m1; } exp_t;
  exp_t sb[$];
  logic [15:0] cur [N];

  always #5 clk = ~clk;

  fft_mag_streamer #(.N(16), .MSB(16), .BITREV(0)) dut (
    .clk(clk), .rst_n(rst_n), .fft_data(fft_data), .fft_finish(fft_finish),
    .out_data(d0), .out_index(i0), .out_valid(v0), .out_ready(out_ready),
    .out_last(l0), .busy(b0), .overrun(o0));

  fft_mag_streamer #(.N(16), .MSB(16), .BITREV(1)) dut_br (
    .clk(clk), .rst_n(rst_n), .fft_data(fft_data), .fft_finish(fft_finish),
    .out_data(d1), .out_index(i1), .out_valid(v1), .out_ready(out_ready),
    .out_last(l1), .busy(b1), .overrun(o1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_m(input logic [15:0] w);
    int re, im;
    re = int'($signed(w[15:8]));
    im = int'($signed(w[7:0]));
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    return (re >= im) ? re + im / 2 : im + re / 2;
  endfunction

  function automatic int rev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cur();
    for (int i = 0; i < N; i++) fft_data[16*i +: 16] = cur[i];
  endtask

  task automatic push_cur();
    for (int k = 0; k < N; k++) sb.push_back('{k, mag_m(cur[k]), mag_m(cur[rev4(k)])});
  endtask

  // Capture a frame from cur; on return the capture edge has passed.
  task automatic start_frame();
    load_cur();
    push_cur();
    fft_finish = 1'b1;
    step();
    fft_finish = 1'b0;
  endtask

  task automatic rand_cur();
    for (int i = 0; i < N; i++) cur[i] = 16'($urandom);
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {v0, l0, b0, o0, d0, i0}, 0);
    chk({tag, "_br"}, {v1, l1, b1, o1, d1, i1}, 0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (b0 || sb.size() != 0); i++) step();
    chk("drain_queue", sb.size(), 0);
    chk("drain_busy", b0, 0);
  endtask

  // Scoreboard and hold-stability monitor.
  logic        hold = 1'b0;
  logic [14:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {d0, i0, l0, v0, d1[0]}, {held[14:1], 1'b1, held[0]});
      if (v0 && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_extra_beat observed_index=%0d expected=none", i0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("index", i0, e.idx);
          chk("index_br", i1, e.idx);
          chk("mag", d0, e.m0);
          chk("mag_br", d1, e.m1);
          chk("last", l0, (e.idx == N - 1));
        end
      end
      hold = v0 && !out_ready;
      held = {d0, i0, l0, d1[0]};
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    fft_finish = 1'b0;
    out_ready = 1'b1;
    fft_data = '0;
    for (int i = 0; i < N; i++) cur[i] = '0;
    repeat (3) step();
    outs_zero("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      outs_zero("idle");
    end

    // Magnitude arithmetic frame.
    cur[0] = 16'h0304; cur[1] = 16'h8080; cur[2] = 16'hFD00; cur[3] = 16'h7F81;
    start_frame();
    chk("latency_valid", v0, 1);
    chk("latency_index", i0, 0);
    n = 0;
    while (b0 && n < 40) begin
      n++;
      step();
    end
    chk("busy_cycles", n, 16);
    wait_drain(40);

    // Bit-reversal frame: re=0, im=i.
    for (int i = 0; i < N; i++) cur[i] = 16'(i);
    start_frame();
    wait_drain(40);

    // Back-pressure with random ready.
    rand_cur();
    start_frame();
    for (int i = 0; i < 400 && (b0 || sb.size() != 0); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    wait_drain(40);

    // Overrun at beat 5; stream must finish with original data.
    rand_cur();
    start_frame();
    repeat (5) step();
    chk("pre_overrun_index", i0, 5);
    for (int i = 0; i < N; i++) fft_data[16*i +: 16] = 16'hA5A5 ^ 16'(i);
    fft_finish = 1'b1;
    step();
    fft_finish = 1'b0;
    chk("overrun_pulse", o0, 1);
    chk("overrun_pulse_br", o1, 1);
    step();
    chk("overrun_clear", o0, 0);
    wait_drain(40);

    // Back-to-back: new frame on the final-transfer edge.
    rand_cur();
    start_frame();
    repeat (15) step();
    chk("b2b_last_index", i0, 15);
    chk("b2b_last_flag", l0, 1);
    rand_cur();
    load_cur();
    push_cur();
    fft_finish = 1'b1;
    step();
    fft_finish = 1'b0;
    chk("b2b_no_overrun", o0, 0);
    chk("b2b_valid", v0, 1);
    chk("b2b_index", i0, 0);
    chk("b2b_busy", b0, 1);
    wait_drain(60);

    // Reset mid-stream at beat 7.
    rand_cur();
    start_frame();
    repeat (7) step();
    chk("pre_reset_index", i0, 7);
    rst_n = 1'b0;
    #1;
    outs_zero("async_reset");
    sb.delete();
    step();
    outs_zero("reset_hold");
    rst_n = 1'b1;
    step();
    outs_zero("after_reset");
    rand_cur();
    start_frame();
    chk("restart_index", i0, 0);
    wait_drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_mag_streamer.md
# fft_mag_streamer

Downstream consumer of the FFT core. On the core's one-cycle `fft_finish` pulse it captures the flat `N*MSB` result bus into a local frame buffer. It then streams one magnitude estimate per bin over a valid/ready interface, in natural bin order, with optional bit-reversal reordering. It frees the FFT core to start the next frame immediately and gives downstream logic (UART packer, LED display) a narrow, back-pressurable sample stream.

## Interface
Parameters:
- `N`, 16, number of FFT bins; power of two, ≥4.
- `MSB`, 16, bits per bin word; even. Upper `MSB/2` bits are signed real, lower `MSB/2` bits are signed imaginary (two's complement).
- `BITREV`, 1. When 1, output bin k is read from buffer slot bitrev(k) over `$clog2(N)` bits. When 0, it is read from slot k.

Ports (H = MSB/2, A = $clog2(N)):
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fft_data`  in  MSB*N  FFT result bus; bin i occupies bits [MSB*i +: MSB].
- `fft_finish`  in  1  one-cycle pulse: `fft_data` valid this cycle.
- `out_data`  out  H+1  unsigned magnitude estimate.
- `out_index`  out  A  natural-order bin number of `out_data`.
- `out_valid`  out  1  `out_data`/`out_index` valid.
- `out_ready`  in  1  consumer accepts the current beat.
- `out_last`  out  1  high with the beat for bin N-1.
- `busy`  out  1  a frame is captured and not yet fully transferred.
- `overrun`  out  1  one-cycle pulse: a frame was dropped.

## Operation
- States: IDLE, STREAM.
- IDLE, `fft_finish`=1 at an edge:
  - `fft_data` is copied into the buffer.
  - bin counter is cleared.
  - go to STREAM, `busy`=1, `out_valid`=1 with bin 0 from the next cycle.
- STREAM:
  - The output register holds the beat for counter k.
  - Transfer occurs on an edge where `out_valid && out_ready`.
  - On transfer with k<N-1: k←k+1 and the output register loads bin k+1 at that same edge, so there are no bubbles.
  - On transfer with k=N-1 (`out_last`=1): go to IDLE, `out_valid`=0, `busy`=0.
- Hold: while `out_ready`=0, `out_data`, `out_index` and `out_last` remain stable.
- Magnitude:
  - re/im are sign-extended and made absolute, giving H-bit unsigned values (|−2^(H−1)| = 2^(H−1) fits).
  - `out_data` = max(|re|,|im|) + (min(|re|,|im|) >> 1), zero-extended to H+1 bits.
  - The result is computed from the buffered word and registered into `out_data`; there are no truncation or saturation cases.
- `fft_finish` during STREAM, other than on the final-transfer edge: the frame is ignored, `overrun` pulses for 1 cycle, and the current stream continues unaffected.
- `fft_finish` coinciding with the final transfer (k=N-1, `out_ready`=1):
  - the new frame is captured;
  - the state stays STREAM, k←0, bin 0 of the new frame is presented the next cycle;
  - `busy` stays 1, no overrun.
- `fft_data` is sampled only on the capture edge; later changes on it do not affect the buffer.

## Timing
- Reset values (async assertion, deasserted synchronously by the system):
  - state IDLE;
  - `out_valid`, `out_last`, `busy`, `overrun` = 0;
  - `out_data`, `out_index` = 0;
  - counter = 0.
  - Buffer contents are don't-care.
- Reset asserted mid-stream aborts the frame immediately, with outputs at reset values. The first `fft_finish` after release starts a fresh frame.
- Latency: from the `fft_finish` edge to the first `out_valid`=1 is 1 cycle.
- Throughput: 1 bin/cycle with `out_ready` held at 1. A frame takes N cycles, so `busy` is high for exactly N cycles.
- `out_last` = `out_valid` && (`out_index` == N-1); it is registered, not combinational from `out_ready`.
- No combinational path from `out_ready` to any output.

## Test plan
- Reset/idle: hold `rst_n`=0, then release with no `fft_finish` → all outputs stay 0 for 20 cycles.
- Magnitude arithmetic (N=16, MSB=16, BITREV=0):
  - stimulus: bin0=0x0304, bin1=0x8080, bin2=0xFD00, bin3=0x7F81, others 0; `out_ready`=1.
  - required beats: 5, 192, 3, 190 for bins 0–3, then 0 for bins 4–15.
  - `out_last` only on index 15; `busy` high exactly 16 cycles.
- Bit reversal (BITREV=1): slot i = i (re=0, im=i) → `out_index` 0..15 carries magnitudes 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- Back-pressure: random `out_ready` (~50%) → every index 0..15 is delivered exactly once, in order. Outputs are stable whenever `out_valid`=1 and `out_ready`=0.
- Overrun and back-to-back frames:
  - `fft_finish` at beat 5 of a stream → `overrun` pulses 1 cycle, the stream completes with the original data.
  - `fft_finish` on the final-transfer edge → the new frame's bin 0 follows with no idle cycle, no overrun.
- Reset mid-stream: assert `rst_n`=0 at beat 7 → outputs drop to 0 asynchronously. The next frame restarts at index 0 with correct data.
